// File: rtl/mantissa_div_seq.sv
// Iterative restoring mantissa divider: one quotient bit per clock, early exit on zero
// remainder, and a sticky bit for the rounding stage. Exceptions (dbz/ovf) resolve in one step.
module mantissa_div_seq #(
    parameter int WIDTH = 24,
    parameter int EXTRA = 3,
    localparam int QW = WIDTH + EXTRA,
    localparam int CW = $clog2(QW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [QW-1:0]    quotient,
    output logic             sticky,
    output logic             dbz,
    output logic             ovf,
    output logic [0:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle when results
    // become valid, and results hold until the done of the next accepted start.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             exc_dbz;
    logic             exc_ovf;

    // The top quotient bit is always shifted out before it is reused, so only QW-1 bits are kept.
    logic [QW-2:0]    q;

    logic [WIDTH+1:0] trial;
    logic             q_bit;
    logic [WIDTH:0]   r_next;
    logic [QW-1:0]    q_next;
    logic             last_step;
    logic [CW-1:0]    shamt;
    logic             div_zero;
    logic             too_big;

    assign busy      = (state == RUN);
    assign dbg_state = state;

    assign div_zero = (divisor == '0);
    assign too_big  = ({1'b0, dividend} >= {divisor, 1'b0});

    always_comb begin
        trial     = {1'b0, rem} - {2'b00, dvs};
        q_bit     = ~trial[WIDTH+1];
        r_next    = q_bit ? trial[WIDTH:0] : rem;
        q_next    = {q, q_bit};
        last_step = (r_next == '0) || (cnt == CW'(1));
        shamt     = cnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            quotient <= '0;
            sticky   <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            rem      <= '0;
            dvs      <= '0;
            q        <= '0;
            cnt      <= '0;
            exc_dbz  <= 1'b0;
            exc_ovf  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem     <= {1'b0, dividend};
                        dvs     <= divisor;
                        q       <= '0;
                        cnt     <= CW'(QW);
                        exc_dbz <= div_zero;
                        exc_ovf <= !div_zero && too_big;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Exceptions spend one cycle here so done lands at the normal minimum latency.
                    if (exc_dbz || exc_ovf) begin
                        quotient <= '1;
                        sticky   <= 1'b0;
                        dbz      <= exc_dbz;
                        ovf      <= exc_ovf;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        q   <= q_next[QW-2:0];
                        rem <= {r_next[WIDTH-1:0], 1'b0};
                        cnt <= cnt - CW'(1);
                        if (last_step) begin
                            quotient <= q_next << shamt;
                            sticky   <= (r_next != '0);
                            dbz      <= 1'b0;
                            ovf      <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
